mem_srv: RTL and testbench

// - Memory-side responder for the accelerator client read/write ports (pool, conv, fc engines).
// - Owns a byte-addressed scratchpad and serves one read port and one write port,
//   one transfer at a time, with a 2-way round-robin arbiter between them.
// - Used as the engines' data memory in block-level benches and as the on-chip buffer in top-level integration.

---
 rtl/mem_srv_pkg.sv | 19 +
 rtl/mem_srv_arb.sv | 27 ++
 rtl/mem_srv.sv | 116 +++++++++++
 tb/tb_mem_srv.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_srv_pkg.sv
// Shared types and sizing helpers for the scratchpad responder.
package mem_srv_pkg;

   typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT} mem_srv_state_e;

   function automatic int bytes_of(input int bus_bits);
      return bus_bits / 8;
   endfunction

   function automatic int size_w_of(input int bus_bits);
      return $clog2(bus_bits / 8 + 1);
   endfunction

   // Oversized requests are served as a full-bus transfer.
   function automatic int clamp_size(input int size, input int bytes);
      return (size > bytes) ? bytes : size;
   endfunction

endpackage

// File: rtl/mem_srv_arb.sv
// Two-way round-robin arbiter between the read and write ports.
module mem_srv_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_rd,
   input  logic       req_wr,
   input  logic       enable,
   output logic [1:0] gnt      // bit 0 read, bit 1 write
);

   logic last_wr;

   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         if (req_rd && req_wr) gnt = last_wr ? 2'b01 : 2'b10;
         else                  gnt = {req_wr, req_rd};
      end
   end

   // Reset to "last was read" so the write port wins the first contest.
   always_ff @(posedge clk) begin
      if (rst)                             last_wr <= 1'b0;
      else if (enable && (req_rd || req_wr)) last_wr <= gnt[1];
   end

endmodule

// File: rtl/mem_srv.sv
// Byte-addressed scratchpad serving one read and one write port, one transfer at a time.
module mem_srv
   import mem_srv_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int MEM_DATA_BUS = 128,
   parameter int RD_LAT       = 2,
   localparam int BYTES       = bytes_of(MEM_DATA_BUS),
   localparam int SIZE_W      = size_w_of(MEM_DATA_BUS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rd_req,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [SIZE_W-1:0]       rd_size,
   output logic                    rd_gnt,
   output logic                    rd_valid,
   output logic [MEM_DATA_BUS-1:0] rd_data,
   input  logic                    wr_req,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [SIZE_W-1:0]       wr_size,
   input  logic [MEM_DATA_BUS-1:0] wr_data,
   output logic                    wr_gnt,
   output logic                    busy
);

   mem_srv_state_e          state;
   logic [7:0]              mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0]   r_addr, sel_addr;
   logic [SIZE_W-1:0]       r_size, sel_size, w_size;
   logic [3:0]              lat_cnt;
   logic [MEM_DATA_BUS-1:0] rdata_n;
   logic [1:0]              gnt;
   logic                    idle;

   assign idle = (state == IDLE);
   assign busy = !idle;

   mem_srv_arb u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_rd (rd_req),
      .req_wr (wr_req),
      .enable (idle),
      .gnt    (gnt)
   );

   assign w_size   = SIZE_W'(clamp_size(int'(wr_size), BYTES));
   // In IDLE the read path looks at the live request so RD_LAT=1 can answer on acceptance.
   assign sel_addr = idle ? rd_addr : r_addr;
   assign sel_size = idle ? SIZE_W'(clamp_size(int'(rd_size), BYTES)) : r_size;

   always_comb begin
      rdata_n = '0;
      for (int i = 0; i < BYTES; i++)
         if (i < int'(sel_size)) rdata_n[8*i +: 8] = mem[sel_addr + ADDR_WIDTH'(i)];
   end

   // Address arithmetic wraps naturally at the top of memory.
   always_ff @(posedge clk) begin
      if (!rst && gnt[1])
         for (int i = 0; i < BYTES; i++)
            if (i < int'(w_size)) mem[wr_addr + ADDR_WIDTH'(i)] <= wr_data[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rd_gnt   <= 1'b0;
         rd_valid <= 1'b0;
         wr_gnt   <= 1'b0;
         rd_data  <= '0;
         lat_cnt  <= '0;
         r_addr   <= '0;
         r_size   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt[1]) begin
                  state  <= WR_ACK;
                  wr_gnt <= 1'b1;
               end else if (gnt[0]) begin
                  state   <= RD_WAIT;
                  rd_gnt  <= 1'b1;
                  r_addr  <= rd_addr;
                  r_size  <= sel_size;
                  lat_cnt <= 4'(RD_LAT - 1);
                  if (RD_LAT == 1) begin
                     rd_valid <= 1'b1;
                     rd_data  <= rdata_n;
                  end
               end
            end
            WR_ACK: begin
               wr_gnt <= 1'b0;
               state  <= IDLE;
            end
            RD_WAIT: begin
               rd_gnt <= 1'b0;
               if (lat_cnt == 4'd0) begin
                  rd_valid <= 1'b0;
                  state    <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
                  if (lat_cnt == 4'd1) begin
                     rd_valid <= 1'b1;
                     rd_data  <= rdata_n;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_srv.sv
// Bench for mem_srv: vector table plus scoreboarded reads and hand-timed corner sequences.
module tb_mem_srv;

   localparam logic [127:0] D0 = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] D1 = 128'h0F0E0D0C0B0A09080711223303020100;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rd_req = 1'b0, wr_req = 1'b0;
   logic [11:0]  rd_addr = '0, wr_addr = '0;
   logic [4:0]   rd_size = '0, wr_size = '0;
   logic [127:0] wr_data = '0;
   logic         rd_gnt, rd_valid, wr_gnt, busy;
   logic [127:0] rd_data;

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q[$];

   typedef struct {
      logic         is_wr;
      logic [11:0]  addr;
      logic [4:0]   size;
      logic [127:0] data;   // write payload or expected read data
   } vec_t;
   vec_t tbl[11];

   mem_srv dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size),
      .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
      .wr_gnt(wr_gnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_valid_unexpected: got data %h expected no response", rd_data);
         end else begin
            chk("rd_data", rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic wait_idle();
      for (int c = 0; c < 20; c++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("return_idle", busy, 0);
   endtask

   task automatic issue(input logic is_wr, input logic [11:0] addr, input logic [4:0] size,
                        input logic [127:0] data);
      logic ok = 1'b0;
      if (is_wr) begin
         wr_req = 1; wr_addr = addr; wr_size = size; wr_data = data;
      end else begin
         rd_req = 1; rd_addr = addr; rd_size = size;
         exp_q.push_back(data);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (is_wr ? wr_gnt : rd_gnt) begin ok = 1'b1; break; end
      end
      chk(is_wr ? "wr_gnt_seen" : "rd_gnt_seen", ok, 1);
      wr_req = 0; rd_req = 0;
      wait_idle();
   endtask

   task automatic pair(input logic [7:0] wv, input logic [7:0] rexp, input string expo);
      string ord = "";
      wr_req = 1; wr_addr = 12'h200; wr_size = 1; wr_data = {120'b0, wv};
      rd_req = 1; rd_addr = 12'h200; rd_size = 1;
      exp_q.push_back({120'b0, rexp});
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (wr_gnt) begin ord = {ord, "W"}; wr_req = 0; end
         if (rd_gnt) begin ord = {ord, "R"}; rd_req = 0; end
         if (ord.len() >= 2) break;
      end
      checks++;
      if (ord != expo) begin
         errors++;
         $display("FAIL arb_order: got '%s' expected '%s'", ord, expo);
      end
      wr_req = 0; rd_req = 0;
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      tbl[0]  = '{1'b1, 12'h100, 5'd16, D0};
      tbl[1]  = '{1'b0, 12'h100, 5'd16, D0};
      tbl[2]  = '{1'b1, 12'hFFE, 5'd4,  128'hAABBCCDD};
      tbl[3]  = '{1'b0, 12'hFFE, 5'd4,  128'hAABBCCDD};
      tbl[4]  = '{1'b0, 12'h000, 5'd2,  128'hAABB};
      tbl[5]  = '{1'b0, 12'h100, 5'd0,  128'h0};
      tbl[6]  = '{1'b0, 12'h100, 5'd20, D0};
      tbl[7]  = '{1'b1, 12'h100, 5'd0,  {16{8'hFF}}};
      tbl[8]  = '{1'b0, 12'h100, 5'd16, D0};
      tbl[9]  = '{1'b1, 12'h104, 5'd3,  {{13{8'hFF}}, 24'h112233}};
      tbl[10] = '{1'b0, 12'h102, 5'd8,  128'h0908071122330302};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_gnt", rd_gnt, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_wr_gnt", wr_gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_data", rd_data, 0);
      rst = 0;

      // Cycle-exact write then read latency.
      wr_req = 1; wr_addr = 12'h100; wr_size = 16; wr_data = D0;
      @(negedge clk);
      chk("wr_gnt_plus1", wr_gnt, 1);
      chk("busy_wr_ack", busy, 1);
      wr_req = 0;
      @(negedge clk);
      chk("wr_gnt_pulse_end", wr_gnt, 0);
      chk("idle_after_wr", busy, 0);
      rd_req = 1; rd_addr = 12'h100; rd_size = 16;
      exp_q.push_back(D0);
      @(negedge clk);
      chk("rd_gnt_plus1", rd_gnt, 1);
      chk("rd_valid_not_yet", rd_valid, 0);
      rd_req = 0;
      @(negedge clk);
      chk("rd_gnt_pulse_end", rd_gnt, 0);
      chk("rd_valid_plus2", rd_valid, 1);
      @(negedge clk);
      chk("rd_valid_pulse_end", rd_valid, 0);
      chk("idle_after_rd", busy, 0);
      chk("rd_data_hold", rd_data, D0);

      // Arbitration: fresh reset favours write, then round-robin.
      rst = 1;
      @(negedge clk);
      rst = 0;
      pair(8'h5A, 8'h5A, "WR");
      pair(8'hA5, 8'hA5, "WR");
      issue(1'b1, 12'h200, 5'd1, 128'hC3);
      pair(8'h3C, 8'hC3, "RW");

      foreach (tbl[i]) issue(tbl[i].is_wr, tbl[i].addr, tbl[i].size, tbl[i].data);

      // Reset while a read is in flight: no response, memory intact.
      rd_req = 1; rd_addr = 12'h100; rd_size = 16;
      ok = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rd_gnt) begin ok = 1; break; end
      end
      chk("rdwait_gnt_seen", ok, 1);
      rst = 1; rd_req = 0;
      @(negedge clk);
      chk("midrst_rd_valid", rd_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_data", rd_data, 0);
      rst = 0;
      repeat (3) @(negedge clk);
      issue(1'b0, 12'h100, 5'd16, D1);

      // rd_req held past rd_gnt becomes a second read at the next IDLE cycle.
      rd_req = 1; rd_addr = 12'h100; rd_size = 16;
      exp_q.push_back(D1);
      exp_q.push_back(D1);
      ok = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rd_gnt) begin ok = 1; break; end
      end
      chk("hold_gnt1_seen", ok, 1);
      @(negedge clk);
      chk("hold_valid1", rd_valid, 1);
      @(negedge clk);
      chk("hold_idle_gap", busy, 0);
      @(negedge clk);
      chk("hold_gnt2", rd_gnt, 1);
      rd_req = 0;
      wait_idle();

      // A write raised during RD_WAIT waits for IDLE.
      rd_req = 1; rd_addr = 12'h102; rd_size = 8;
      exp_q.push_back(128'h0908071122330302);
      ok = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rd_gnt) begin ok = 1; break; end
      end
      chk("late_wr_rd_gnt", ok, 1);
      rd_req = 0;
      wr_req = 1; wr_addr = 12'h300; wr_size = 1; wr_data = 128'h99;
      @(negedge clk);
      chk("late_wr_blocked1", wr_gnt, 0);
      @(negedge clk);
      chk("late_wr_blocked2", wr_gnt, 0);
      @(negedge clk);
      chk("late_wr_gnt", wr_gnt, 1);
      wr_req = 0;
      wait_idle();
      issue(1'b0, 12'h300, 5'd1, 128'h99);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
